spi_slave_shift: RTL and testbench
==================================

# spi_slave_shift

SPI responder (slave) for the SPI interface: serial-to-parallel receiver on MOSI plus parallel-to-serial transmitter on MISO. It sits opposite the master-side shift register. SCLK, SS_N and MOSI are oversampled by the local system clock, and frames are MSB first. Completed words are presented on RX_DATA with a one-cycle RX_VALID strobe.

## Interface
- WIDTH, 4, frame length in bits (≥2)
- CLK  input  1  system clock; all state updates on rising edge
- CLR  input  1  asynchronous, active-high reset
- SCLK  input  1  SPI clock from master, asynchronous to CLK, SPI mode 0 (CPOL=0, CPHA=0)
- SS_N  input  1  slave select, active-low, asynchronous
- MOSI  input  1  master-out serial data
- MISO  output  1  slave-out serial data
- TX_DATA  input  WIDTH  word to transmit; captured at frame start and at each frame boundary
- RX_DATA  output  WIDTH  last complete received word
- RX_VALID  output  1  one-CLK pulse when RX_DATA updates
- FRAME_ERR  output  1  one-CLK pulse on an aborted frame
- BUSY  output  1  high while state is ACTIVE

## Operation
- SCLK, SS_N and MOSI each pass through a 2-FF synchronizer. A third stage provides edge detection: sclk_rise, sclk_fall, ss_fall, ss_rise.
- State machine:
  - IDLE → ACTIVE on ss_fall: tx_shift ← TX_DATA, MISO ← TX_DATA[WIDTH-1], bit_cnt ← 0.
  - ACTIVE → IDLE on ss_rise.
- In ACTIVE, on sclk_rise:
  - rx_shift ← {rx_shift[WIDTH-2:0], MOSI_sync}.
  - bit_cnt increments. When it reaches WIDTH it wraps to 0, RX_DATA ← the shifted value, and RX_VALID pulses.
- In ACTIVE, on sclk_fall:
  - If bit_cnt == 0 (just completed a frame): tx_shift ← TX_DATA. This supports back-to-back frames without releasing SS_N.
  - Otherwise: tx_shift shifts left.
  - In both cases MISO ← the new tx_shift[WIDTH-1].
- ss_rise with bit_cnt ≠ 0: abort. FRAME_ERR pulses, RX_VALID does not pulse, RX_DATA is unchanged, and the partial rx_shift is discarded.
- ss_rise with bit_cnt == 0: clean end, no pulse.
- sclk_rise/sclk_fall while in IDLE are ignored.
- ss_fall coincident with a SCLK edge: the frame start takes priority; that SCLK edge is ignored.
- CLR asserted at any time, including mid-frame: immediate return to IDLE, all outputs to reset values, partial frame discarded, no pulses.

## Timing
- Reset values: MISO 0, RX_DATA 0, RX_VALID 0, FRAME_ERR 0, BUSY 0, bit_cnt 0, shift registers 0.
- Input-to-action latency: 3 CLK cycles from an SCLK/SS_N pin transition to the registered effect (2 synchronizer cycles + 1 edge-detect cycle).
- RX_VALID goes high 3 CLK cycles after the WIDTH-th SCLK rising edge. It is high for exactly one CLK cycle.
- MISO update: 3 CLK cycles after the SCLK falling edge, or after the SS_N falling edge for the first bit.
- Master constraints:
  - SCLK high and low phases each ≥ 4 CLK periods.
  - SS_N low to first SCLK rise ≥ 4 CLK periods.
  - TX_DATA stable from 4 CLK before SS_N fall, and around each frame-boundary SCLK fall.
- BUSY rises 3 CLK cycles after SS_N falls and drops 3 CLK cycles after SS_N rises.
- FRAME_ERR is coincident with BUSY falling.

## Configuration
- SPI_SLAVE_MISO_TRISTATE_EN:
  - Defined: MISO is 1'bz whenever the state is IDLE or CLR is high, which allows a shared MISO bus with multiple slaves. Driven only in ACTIVE.
  - Undefined: MISO is always driven; it is 0 in IDLE and after reset.

## Test plan
- Reset: hold CLR high with SCLK toggling and SS_N low → all outputs stay at reset values. Release CLR → IDLE, BUSY 0.
- Single frame, WIDTH=4: TX_DATA=4'b0110, MOSI bits 1,0,1,1 on SCLK rises → MISO presents 0,1,1,0 before the respective rises; RX_DATA=4'b1011; one RX_VALID pulse; FRAME_ERR 0.
- Back-to-back: SS_N held low for 8 SCLK cycles. TX_DATA changes from 4'b1001 to 4'b0011 before the 4th fall. MOSI sends 4'b1100 then 4'b0101 → two RX_VALID pulses with RX_DATA 4'b1100 then 4'b0101; MISO sends 1,0,0,1,0,0,1,1.
- Abort: SS_N rises after 2 SCLK rises → FRAME_ERR pulses once, RX_VALID stays 0, RX_DATA keeps its prior value. The next full frame is received correctly.
- CLR mid-frame: assert after 3 bits → outputs reset immediately. After release, a fresh 4-bit frame with MOSI 4'b0111 yields RX_DATA=4'b0111.
- Macro: with SPI_SLAVE_MISO_TRISTATE_EN defined, MISO is z in IDLE and driven during ACTIVE. Without it, MISO is 0 in IDLE.

Source files
------------

// File: rtl/spi_slave_shift.sv
// SPI mode-0 responder with oversampled SCLK/SS_N/MOSI, MSB-first frames.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN releases MISO outside ACTIVE.
module spi_slave_shift #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic ss_s1, ss_s2, ss_s3;
  logic mosi_s1, mosi_s2;

  logic sclk_rise, sclk_fall;
  logic ss_fall, ss_rise;

  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [CW-1:0]    bit_cnt;
  logic             miso_r;

  // Sync stages reset low so a select already held low at reset
  // release never looks like a fresh frame start.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_s3   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ss_s1   <= SS_N;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign ss_fall   = ~ss_s2 & ss_s3;
  assign ss_rise   = ss_s2 & ~ss_s3;

  assign rx_next = {rx_shift[WIDTH-2:0], mosi_s2};

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      miso_r    <= 1'b0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= ACTIVE;
            tx_shift <= TX_DATA;
            miso_r   <= TX_DATA[WIDTH-1];
            rx_shift <= '0;
            bit_cnt  <= '0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state     <= IDLE;
            FRAME_ERR <= (bit_cnt != '0);
            bit_cnt   <= '0;
            rx_shift  <= '0;
            miso_r    <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST) begin
              bit_cnt  <= '0;
              RX_DATA  <= rx_next;
              RX_VALID <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            // A fall right after a completed word reloads for the next frame.
            if (bit_cnt == '0) begin
              tx_shift <= TX_DATA;
              miso_r   <= TX_DATA[WIDTH-1];
            end else begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              miso_r   <= tx_shift[WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state == ACTIVE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = (state == ACTIVE && !CLR) ? miso_r : 1'bz;
`else
  assign MISO = miso_r;
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Bench for spi_slave_shift: directed test-plan steps plus random
// transfers checked against a word-level model of the SPI exchange.
module tb_spi_slave_shift;

  localparam int H = 6;

  logic       clk;
  logic       clr;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [3:0] tx;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] q_rx[$];
  int         n_err = 0;
  int         n_bad = 0;
  logic       prev_busy = 1'b0;

  logic [3:0] tx_w[8];
  logic [3:0] rx_w[8];
  logic [3:0] exp_rx;
  logic       idle_miso;

  spi_slave_shift #(.WIDTH(4)) dut (
    .CLK(clk),
    .CLR(clr),
    .SCLK(sclk),
    .SS_N(ss_n),
    .MOSI(mosi),
    .MISO(miso),
    .TX_DATA(tx),
    .RX_DATA(rx_data),
    .RX_VALID(rx_valid),
    .FRAME_ERR(frame_err),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) q_rx.push_back(rx_data);
    if (frame_err === 1'b1) begin
      n_err++;
      if (busy !== 1'b0 || prev_busy !== 1'b1) n_bad++;
    end
    prev_busy = busy;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int nbits);
    int full;
    int e0;
    logic [3:0] got[8];
    full = nbits / 4;
    q_rx.delete();
    e0 = n_err;
    for (int k = 0; k < 8; k++) got[k] = 4'h0;
    sclk = 1'b0;
    tx = tx_w[0];
    cyc(5);
    ss_n = 1'b0;
    cyc(H);
    for (int i = 0; i < nbits; i++) begin
      int f;
      int p;
      f = i / 4;
      p = i % 4;
      mosi = rx_w[f][3-p];
      if (p == 2 && f < 7) tx = tx_w[f+1];
      cyc(H);
      got[f][3-p] = miso;
      sclk = 1'b1;
      cyc(H);
      sclk = 1'b0;
    end
    cyc(H);
    ss_n = 1'b1;
    cyc(H + 4);
    chk("rx_pulses", q_rx.size(), full);
    for (int k = 0; k < full; k++) begin
      if (k < q_rx.size()) chk("rx_word", q_rx[k], rx_w[k]);
      chk("miso_word", got[k], tx_w[k]);
    end
    chk("frame_err", n_err - e0, (nbits % 4 != 0) ? 1 : 0);
    if (full > 0) exp_rx = rx_w[full-1];
    chk("rx_data_hold", rx_data, exp_rx);
    chk("busy_end", busy, 1'b0);
    chk("miso_idle", miso, idle_miso);
  endtask

  initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    idle_miso = 1'bz;
`else
    idle_miso = 1'b0;
`endif
    exp_rx = 4'h0;
    clr = 1'b1;
    sclk = 1'b0;
    ss_n = 1'b0;
    mosi = 1'b1;
    tx = 4'hF;

    // reset held with pins active
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      cyc(2);
    end
    chk("rst_rx_data", rx_data, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miso", miso, idle_miso);
    chk("rst_pulses", q_rx.size() + n_err, 0);
    sclk = 1'b0;
    clr = 1'b0;
    cyc(6);
    chk("rel_busy", busy, 1'b0);
    ss_n = 1'b1;
    cyc(6);

    // busy latency and clean end
    tx = 4'h0;
    cyc(5);
    ss_n = 1'b0;
    cyc(2);
    chk("busy_lat_2", busy, 1'b0);
    cyc(1);
    chk("busy_lat_3", busy, 1'b1);
    cyc(4);
    ss_n = 1'b1;
    cyc(2);
    chk("busy_drop_2", busy, 1'b1);
    cyc(1);
    chk("busy_drop_3", busy, 1'b0);
    cyc(4);
    chk("clean_no_err", n_err, 0);

    // single frame
    tx_w[0] = 4'b0110;
    rx_w[0] = 4'b1011;
    xfer(4);

    // back-to-back frames
    tx_w[0] = 4'b1001;
    tx_w[1] = 4'b0011;
    rx_w[0] = 4'b1100;
    rx_w[1] = 4'b0101;
    xfer(8);

    // abort then full frame
    rx_w[0] = 4'b1110;
    xfer(2);
    tx_w[0] = 4'b1010;
    rx_w[0] = 4'b0110;
    xfer(4);

    // random transfers
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 8; k++) begin
        tx_w[k] = 4'($urandom);
        rx_w[k] = 4'($urandom);
      end
      xfer($urandom_range(1, 12));
    end

    // clear mid-frame
    begin
      int e0;
      e0 = n_err;
      q_rx.delete();
      tx = 4'b1111;
      cyc(5);
      ss_n = 1'b0;
      cyc(H);
      for (int i = 0; i < 3; i++) begin
        mosi = 1'b1;
        cyc(H);
        sclk = 1'b1;
        cyc(H);
        if (i < 2) sclk = 1'b0;
      end
      chk("pre_clr_busy", busy, 1'b1);
      clr = 1'b1;
      #1;
      chk("clr_rx_data", rx_data, 4'h0);
      chk("clr_busy", busy, 1'b0);
      chk("clr_miso", miso, idle_miso);
      chk("clr_rx_valid", rx_valid, 1'b0);
      sclk = 1'b0;
      ss_n = 1'b1;
      cyc(4);
      clr = 1'b0;
      cyc(6);
      chk("clr_no_pulse", (n_err - e0) + q_rx.size(), 0);
    end

    // fresh frame after clear, with RX_VALID latency
    tx = 4'b0101;
    cyc(5);
    ss_n = 1'b0;
    cyc(H);
    for (int i = 0; i < 3; i++) begin
      mosi = (i == 0) ? 1'b0 : 1'b1;
      cyc(H);
      sclk = 1'b1;
      cyc(H);
      sclk = 1'b0;
    end
    mosi = 1'b1;
    cyc(H);
    sclk = 1'b1;
    cyc(2);
    chk("rxv_lat_2", rx_valid, 1'b0);
    cyc(1);
    chk("rxv_lat_3", rx_valid, 1'b1);
    chk("fresh_rx", rx_data, 4'b0111);
    cyc(1);
    chk("rxv_width", rx_valid, 1'b0);
    cyc(H);
    sclk = 1'b0;
    cyc(H);
    ss_n = 1'b1;
    cyc(H + 4);
    chk("err_vs_busy", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
